// File: rtl/track_map_writer.sv
// ---------------------------------------------------------------------------
// track_map_writer
//
// Tile map store for a track renderer. It holds a 2^MAP_LOG2 x 2^MAP_LOG2
// map of TILE_W-bit tile codes. A command port writes single tiles or fills
// the whole map (and optionally one row) with a tile code. A separate
// renderer read port returns the tile at {row, column}.
//
// Optional feature macro: TRACK_MAP_ROWFILL_EN
//   defined   : op 10 fills one row of the map
//   undefined : op 10 behaves like op 11 (no write, done pulse); no row-fill
//               state or row register is built
//
// Ports
//   clk_in         single clock
//   rst_in         asynchronous active-low reset (map contents are kept)
//   cmd_valid_in   command offered
//   cmd_ready_out  command accepted when high together with cmd_valid_in
//   cmd_op_in      00 write tile, 01 fill map, 10 fill row, 11 reserved
//   cmd_x_in       tile column
//   cmd_y_in       tile row
//   cmd_tile_in    tile code to store
//   rd_addr_in     renderer read address {row, column}
//   rd_data_out    tile code at rd_addr_in, sampled-edge + 2 edges later
//   busy_out       high while a fill is in progress
//   done_out       one-cycle pulse after a command completes
// ---------------------------------------------------------------------------
module track_map_writer #(
    parameter int MAP_LOG2 = 4,
    parameter int TILE_W   = 4
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    cmd_valid_in,
    output logic                    cmd_ready_out,
    input  logic [1:0]              cmd_op_in,
    input  logic [MAP_LOG2-1:0]     cmd_x_in,
    input  logic [MAP_LOG2-1:0]     cmd_y_in,
    input  logic [TILE_W-1:0]       cmd_tile_in,
    input  logic [2*MAP_LOG2-1:0]   rd_addr_in,
    output logic [TILE_W-1:0]       rd_data_out,
    output logic                    busy_out,
    output logic                    done_out
);

    localparam int AW    = 2 * MAP_LOG2;
    localparam int DEPTH = 1 << AW;

    localparam logic [AW-1:0]       CNT_LAST = '1;
    localparam logic [MAP_LOG2-1:0] COL_LAST = '1;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_FILL  = 2'b01;
`ifdef TRACK_MAP_ROWFILL_EN
    localparam logic [1:0] OP_ROW   = 2'b10;
`endif

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILL    = 2'd1
`ifdef TRACK_MAP_ROWFILL_EN
        ,
        ST_ROWFILL = 2'd2
`endif
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [AW-1:0]       cnt_q;
    logic [AW-1:0]       cnt_d;
    logic [TILE_W-1:0]   tile_q;
    logic [TILE_W-1:0]   tile_d;
    logic                done_q;
    logic                done_d;
`ifdef TRACK_MAP_ROWFILL_EN
    logic [MAP_LOG2-1:0] row_q;
    logic [MAP_LOG2-1:0] row_d;
`endif

    logic                accept_s;
    logic                we_s;
    logic [AW-1:0]       waddr_s;
    logic [TILE_W-1:0]   wdata_s;

    logic [TILE_W-1:0]   mem_q [DEPTH];
    logic [TILE_W-1:0]   rd_s1_q;
    logic [TILE_W-1:0]   rd_s2_q;
    logic [TILE_W-1:0]   rd_data_q;

    assign accept_s      = cmd_valid_in && (state_q == ST_IDLE);
    assign cmd_ready_out = (state_q == ST_IDLE);
    assign busy_out      = (state_q != ST_IDLE);
    assign done_out      = done_q;
    assign rd_data_out   = rd_data_q;

    // State register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: fills end on the edge that writes the last address.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    case (cmd_op_in)
                        OP_FILL: state_d = ST_FILL;
`ifdef TRACK_MAP_ROWFILL_EN
                        OP_ROW:  state_d = ST_ROWFILL;
`endif
                        default: state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FILL;
                end
            end
`ifdef TRACK_MAP_ROWFILL_EN
            ST_ROWFILL: begin
                if (cnt_q[MAP_LOG2-1:0] == COL_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ROWFILL;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/datapath decode: write port, counter, latched operands, done.
    always_comb begin
        we_s    = 1'b0;
        waddr_s = '0;
        wdata_s = '0;
        cnt_d   = cnt_q;
        tile_d  = tile_q;
        done_d  = 1'b0;
`ifdef TRACK_MAP_ROWFILL_EN
        row_d   = row_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    case (cmd_op_in)
                        OP_WRITE: begin
                            we_s    = 1'b1;
                            waddr_s = {cmd_y_in, cmd_x_in};
                            wdata_s = cmd_tile_in;
                            done_d  = 1'b1;
                        end
                        OP_FILL: begin
                            cnt_d  = '0;
                            tile_d = cmd_tile_in;
                        end
`ifdef TRACK_MAP_ROWFILL_EN
                        OP_ROW: begin
                            cnt_d  = '0;
                            tile_d = cmd_tile_in;
                            row_d  = cmd_y_in;
                        end
`endif
                        // Reserved op (and row op when row fill is not
                        // built): accepted, nothing written.
                        default: done_d = 1'b1;
                    endcase
                end else begin
                    done_d = 1'b0;
                end
            end
            ST_FILL: begin
                we_s    = 1'b1;
                waddr_s = cnt_q;
                wdata_s = tile_q;
                // Stop on all-ones instead of wrapping, so no extra write.
                if (cnt_q == CNT_LAST) begin
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + {{(AW-1){1'b0}}, 1'b1};
                end
            end
`ifdef TRACK_MAP_ROWFILL_EN
            ST_ROWFILL: begin
                we_s    = 1'b1;
                waddr_s = {row_q, cnt_q[MAP_LOG2-1:0]};
                wdata_s = tile_q;
                if (cnt_q[MAP_LOG2-1:0] == COL_LAST) begin
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + {{(AW-1){1'b0}}, 1'b1};
                end
            end
`endif
            default: begin
                we_s   = 1'b0;
                done_d = 1'b0;
            end
        endcase
    end

    // Datapath registers: fill counter, latched tile/row, done pulse.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt_q  <= '0;
            tile_q <= '0;
            done_q <= 1'b0;
`ifdef TRACK_MAP_ROWFILL_EN
            row_q  <= '0;
`endif
        end else begin
            cnt_q  <= cnt_d;
            tile_q <= tile_d;
            done_q <= done_d;
`ifdef TRACK_MAP_ROWFILL_EN
            row_q  <= row_d;
`endif
        end
    end

    // Map storage write port; contents survive reset by design.
    always_ff @(posedge clk_in) begin
        if (we_s) begin
            mem_q[waddr_s] <= wdata_s;
        end
    end

    // Read pipeline: the array is read on the sampling edge (old data on a
    // same-edge write), then two stages bring it to the output.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rd_s1_q   <= '0;
            rd_s2_q   <= '0;
            rd_data_q <= '0;
        end else begin
            rd_s1_q   <= mem_q[rd_addr_in];
            rd_s2_q   <= rd_s1_q;
            rd_data_q <= rd_s2_q;
        end
    end

endmodule

// File: tb/tb_track_map_writer.sv
module tb_track_map_writer;

    logic       clk;
    logic       rst_in;
    logic       cmd_valid_in;
    logic       cmd_ready_out;
    logic [1:0] cmd_op_in;
    logic [3:0] cmd_x_in;
    logic [3:0] cmd_y_in;
    logic [3:0] cmd_tile_in;
    logic [7:0] rd_addr_in;
    logic [3:0] rd_data_out;
    logic       busy_out;
    logic       done_out;

    int errors = 0;
    int checks = 0;

    // Reference map and the result of the latest read sweep.
    logic [3:0] model_mem  [256];
    logic [3:0] sweep_data [256];

    track_map_writer #(.MAP_LOG2(4), .TILE_W(4)) dut (
        .clk_in        (clk),
        .rst_in        (rst_in),
        .cmd_valid_in  (cmd_valid_in),
        .cmd_ready_out (cmd_ready_out),
        .cmd_op_in     (cmd_op_in),
        .cmd_x_in      (cmd_x_in),
        .cmd_y_in      (cmd_y_in),
        .cmd_tile_in   (cmd_tile_in),
        .rd_addr_in    (rd_addr_in),
        .rd_data_out   (rd_data_out),
        .busy_out      (busy_out),
        .done_out      (done_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one command for one cycle; returns at the negedge after the
    // accepting edge.
    task automatic issue_cmd(input logic [1:0] op, input int x, input int y, input int tile);
        logic [31:0] xv, yv, tv;
        xv = x; yv = y; tv = tile;
        @(negedge clk);
        cmd_valid_in = 1'b1;
        cmd_op_in    = op;
        cmd_x_in     = xv[3:0];
        cmd_y_in     = yv[3:0];
        cmd_tile_in  = tv[3:0];
        @(negedge clk);
        cmd_valid_in = 1'b0;
    endtask

    // Pipelined sweep of all 256 addresses into sweep_data.
    task automatic read_sweep();
        for (int k = 0; k < 259; k++) begin
            @(negedge clk);
            if (k >= 3) sweep_data[k-3] = rd_data_out;
            if (k < 256) rd_addr_in = 8'(k);
        end
    endtask

    // Full map fill that must finish within a bounded number of cycles.
    task automatic run_fill(input int tile);
        bit finished;
        finished = 1'b0;
        issue_cmd(2'b01, 0, 0, tile);
        for (int i = 0; i < 400 && !finished; i++) begin
            @(negedge clk);
            if (!busy_out) finished = 1'b1;
        end
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL run_fill_timeout: busy=%0b still high, required low within 400 cycles", busy_out);
        end
        for (int a = 0; a < 256; a++) model_mem[a] = 4'(tile);
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (rd_data_out !== 4'd0 || done_out !== 1'b0 || busy_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: rd=%0h done=%0b busy=%0b, required 0 0 0", rd_data_out, done_out, busy_out);
        end
        rst_in = 1'b1;
        #1;
        checks++;
        if (cmd_ready_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: ready=%0b, required 1", cmd_ready_out);
        end
    endtask

    task automatic test_fill();
        int busy_n, last_busy, done_n, done_at, ready_bad;
        busy_n = 0; last_busy = 0; done_n = 0; done_at = 0; ready_bad = 0;
        issue_cmd(2'b01, 0, 0, 2);
        for (int i = 1; i <= 300; i++) begin
            if (i > 1) @(negedge clk);
            // A write offered mid-fill must be dropped, not queued.
            if (i == 50) begin
                cmd_valid_in = 1'b1; cmd_op_in = 2'b00;
                cmd_x_in = 4'd5; cmd_y_in = 4'd0; cmd_tile_in = 4'd9;
            end
            if (i == 52) cmd_valid_in = 1'b0;
            if (busy_out) begin
                busy_n++;
                last_busy = i;
                if (cmd_ready_out) ready_bad++;
            end
            if (done_out) begin
                done_n++;
                done_at = i;
            end
        end
        for (int a = 0; a < 256; a++) model_mem[a] = 4'd2;
        checks++;
        if (busy_n != 256 || last_busy != 256) begin
            errors++;
            $display("FAIL fill_busy_len: busy=%0d last=%0d, required 256 256", busy_n, last_busy);
        end
        checks++;
        if (done_n != 1 || done_at != 257) begin
            errors++;
            $display("FAIL fill_done: count=%0d at=%0d, required 1 at 257", done_n, done_at);
        end
        checks++;
        if (ready_bad != 0) begin
            errors++;
            $display("FAIL fill_ready_low: ready high %0d busy cycles, required 0", ready_bad);
        end
        read_sweep();
        for (int a = 0; a < 256; a++) begin
            checks++;
            if (sweep_data[a] !== model_mem[a]) begin
                errors++;
                $display("FAIL fill_sweep[%0h]: got %0h, required %0h", a, sweep_data[a], model_mem[a]);
            end
        end
    endtask

`ifdef TRACK_MAP_ROWFILL_EN
    task automatic test_rowfill();
        int busy_n, done_n, done_at;
        busy_n = 0; done_n = 0; done_at = 0;
        issue_cmd(2'b10, 0, 9, 4);
        for (int i = 1; i <= 40; i++) begin
            if (i > 1) @(negedge clk);
            if (i == 5) begin
                cmd_valid_in = 1'b1; cmd_op_in = 2'b00;
                cmd_x_in = 4'd0; cmd_y_in = 4'd0; cmd_tile_in = 4'd7;
            end
            if (i == 6) cmd_valid_in = 1'b0;
            if (busy_out) busy_n++;
            if (done_out) begin
                done_n++;
                done_at = i;
            end
        end
        for (int c = 0; c < 16; c++) model_mem[9*16 + c] = 4'd4;
        checks++;
        if (busy_n != 16) begin
            errors++;
            $display("FAIL rowfill_busy_len: busy=%0d, required 16", busy_n);
        end
        checks++;
        if (done_n != 1 || done_at != 17) begin
            errors++;
            $display("FAIL rowfill_done: count=%0d at=%0d, required 1 at 17", done_n, done_at);
        end
        read_sweep();
        for (int a = 0; a < 256; a++) begin
            checks++;
            if (sweep_data[a] !== model_mem[a]) begin
                errors++;
                $display("FAIL rowfill_sweep[%0h]: got %0h, required %0h", a, sweep_data[a], model_mem[a]);
            end
        end
    endtask
`else
    task automatic test_op10_disabled();
        int busy_n;
        busy_n = 0;
        issue_cmd(2'b10, 3, 0, 4);
        checks++;
        if (done_out !== 1'b1) begin
            errors++;
            $display("FAIL op10_done: done=%0b, required 1", done_out);
        end
        if (busy_out) busy_n++;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy_out) busy_n++;
        end
        checks++;
        if (busy_n != 0) begin
            errors++;
            $display("FAIL op10_busy: busy high %0d cycles, required 0", busy_n);
        end
        read_sweep();
        for (int a = 0; a < 256; a++) begin
            checks++;
            if (sweep_data[a] !== model_mem[a]) begin
                errors++;
                $display("FAIL op10_sweep[%0h]: got %0h, required %0h", a, sweep_data[a], model_mem[a]);
            end
        end
    endtask
`endif

    task automatic test_write();
        logic [3:0] got;
        issue_cmd(2'b00, 3, 5, 7);
        model_mem[8'h53] = 4'd7;
        checks++;
        if (done_out !== 1'b1) begin
            errors++;
            $display("FAIL write_done: done=%0b, required 1", done_out);
        end
        @(negedge clk);
        checks++;
        if (done_out !== 1'b0) begin
            errors++;
            $display("FAIL write_done_pulse: done=%0b, required 0", done_out);
        end
        rd_addr_in = 8'h53;
        repeat (3) @(negedge clk);
        got = rd_data_out;
        checks++;
        if (got !== model_mem[8'h53]) begin
            errors++;
            $display("FAIL write_readback: got %0h, required %0h", got, model_mem[8'h53]);
        end
    endtask

    task automatic test_read_first();
        @(negedge clk);
        cmd_valid_in = 1'b1; cmd_op_in = 2'b00;
        cmd_x_in = 4'd1; cmd_y_in = 4'd2; cmd_tile_in = 4'd3;
        rd_addr_in = 8'h53;
        @(negedge clk);
        cmd_tile_in = 4'd6;
        rd_addr_in  = 8'h21;
        @(negedge clk);
        cmd_valid_in = 1'b0;
        @(negedge clk);
        checks++;
        if (rd_data_out !== model_mem[8'h53]) begin
            errors++;
            $display("FAIL rf_prev_addr: got %0h, required %0h", rd_data_out, model_mem[8'h53]);
        end
        @(negedge clk);
        checks++;
        if (rd_data_out !== 4'd3) begin
            errors++;
            $display("FAIL rf_old_data: got %0h, required 3", rd_data_out);
        end
        @(negedge clk);
        checks++;
        if (rd_data_out !== 4'd6) begin
            errors++;
            $display("FAIL rf_new_data: got %0h, required 6", rd_data_out);
        end
        model_mem[8'h21] = 4'd6;
    endtask

    task automatic test_reset_midfill();
        int done_n;
        done_n = 0;
        run_fill(1);
        issue_cmd(2'b01, 0, 0, 5);
        // At negedge i, i-1 fill writes have landed.
        for (int i = 1; i <= 101; i++) begin
            if (i > 1) @(negedge clk);
            if (i <= 100 && done_out) done_n++;
        end
        rst_in = 1'b0;
        #1;
        checks++;
        if (busy_out !== 1'b0 || done_out !== 1'b0 || rd_data_out !== 4'd0) begin
            errors++;
            $display("FAIL midreset_outputs: busy=%0b done=%0b rd=%0h, required 0 0 0", busy_out, done_out, rd_data_out);
        end
        repeat (3) @(negedge clk);
        rst_in = 1'b1;
        #1;
        checks++;
        if (cmd_ready_out !== 1'b1) begin
            errors++;
            $display("FAIL midreset_ready: ready=%0b, required 1", cmd_ready_out);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done_out) done_n++;
        end
        checks++;
        if (done_n != 0) begin
            errors++;
            $display("FAIL midreset_done: %0d done pulses, required 0", done_n);
        end
        for (int a = 0; a < 256; a++) model_mem[a] = (a < 100) ? 4'd5 : 4'd1;
        read_sweep();
        for (int a = 0; a < 256; a++) begin
            checks++;
            if (sweep_data[a] !== model_mem[a]) begin
                errors++;
                $display("FAIL midreset_sweep[%0h]: got %0h, required %0h", a, sweep_data[a], model_mem[a]);
            end
        end
    endtask

    // Random single writes / reserved ops with a random read every cycle.
    task automatic test_random();
        logic [3:0] exp_q[$];
        logic [3:0] exp_v;
        logic [1:0] op;
        logic [7:0] ra;
        logic [3:0] x, y, t;
        bit         v;
        bit         prev_v;
        prev_v = 1'b0;
        for (int j = 0; j < 303; j++) begin
            @(negedge clk);
            if (exp_q.size() == 3) begin
                exp_v = exp_q.pop_front();
                checks++;
                if (rd_data_out !== exp_v) begin
                    errors++;
                    $display("FAIL rand_read[%0d]: got %0h, required %0h", j, rd_data_out, exp_v);
                end
            end
            if (j > 0) begin
                checks++;
                if (done_out !== prev_v) begin
                    errors++;
                    $display("FAIL rand_done[%0d]: got %0b, required %0b", j, done_out, prev_v);
                end
            end
            if (j < 300) begin
                v  = 1'($urandom_range(0, 1));
                op = 2'($urandom_range(0, 3));
                if (op == 2'b01) op = 2'b00;
`ifdef TRACK_MAP_ROWFILL_EN
                if (op == 2'b10) op = 2'b11;
`endif
                x  = 4'($urandom_range(0, 15));
                y  = 4'($urandom_range(0, 15));
                t  = 4'($urandom_range(0, 15));
                ra = 8'($urandom_range(0, 255));
                cmd_valid_in = v; cmd_op_in = op;
                cmd_x_in = x; cmd_y_in = y; cmd_tile_in = t;
                rd_addr_in = ra;
                exp_q.push_back(model_mem[ra]);
                if (v && op == 2'b00) model_mem[{y, x}] = t;
                prev_v = v;
            end else begin
                cmd_valid_in = 1'b0;
                prev_v = 1'b0;
            end
        end
    endtask

    initial begin
        rst_in       = 1'b0;
        cmd_valid_in = 1'b0;
        cmd_op_in    = 2'b00;
        cmd_x_in     = 4'd0;
        cmd_y_in     = 4'd0;
        cmd_tile_in  = 4'd0;
        rd_addr_in   = 8'd0;
        test_reset();
        test_fill();
`ifdef TRACK_MAP_ROWFILL_EN
        test_rowfill();
`else
        test_op10_disabled();
`endif
        test_write();
        test_read_first();
        test_reset_midfill();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/track_map_writer.md
TRACK_MAP_WRITER -- requirements
Module: track_map_writer

Interface
REQ-001 The block SHALL have parameter MAP_LOG2, default 4, giving a map of 2^MAP_LOG2 x 2^MAP_LOG2 tiles.
REQ-002 The block SHALL have parameter TILE_W, default 4, giving the tile-type code width (sprite_type index).
REQ-003 clk_in  input  1  Single clock for all state.
REQ-004 rst_in  input  1  Reset, asynchronous and active-low.
REQ-005 cmd_valid_in  input  1  Command offered.
REQ-006 cmd_ready_out  output  1  Command accepted when high with cmd_valid_in.
REQ-007 cmd_op_in  input  2  Op code: 00 write tile, 01 fill map, 10 fill row, 11 reserved.
REQ-008 cmd_x_in  input  MAP_LOG2  Tile column.
REQ-009 cmd_y_in  input  MAP_LOG2  Tile row.
REQ-010 cmd_tile_in  input  TILE_W  Tile code to store.
REQ-011 rd_addr_in  input  2*MAP_LOG2  Renderer read address, {row, column}.
REQ-012 rd_data_out  output  TILE_W  Tile code at rd_addr_in.
REQ-013 busy_out  output  1  High while a fill is in progress.
REQ-014 done_out  output  1  One-cycle pulse when a command completes.

Function
REQ-015 Storage SHALL be 2^(2*MAP_LOG2) words of TILE_W bits, with one write port and one independent read port, addressed {y, x}.
REQ-016 States SHALL be IDLE, FILL and ROWFILL, and cmd_ready_out SHALL equal (state == IDLE).
REQ-017 Op 00 accepted at edge N SHALL write cmd_tile_in to {cmd_y_in, cmd_x_in} at edge N, stay in IDLE, and pulse done_out during cycle N+1.
REQ-018 Op 01 accepted SHALL latch the tile, enter FILL, and write addresses 0..2^(2*MAP_LOG2)-1, one per cycle in ascending order, starting the cycle after acceptance.
REQ-019 Op 10 accepted SHALL latch the tile and cmd_y_in, enter ROWFILL, and write columns 0..2^MAP_LOG2-1 of that row, one per cycle.
REQ-020 On the edge that writes the last address of a fill, the state SHALL return to IDLE, and done_out SHALL pulse in the following cycle.
REQ-021 A default-parameter map fill SHALL take exactly 256 write cycles; a row fill SHALL take exactly 16.
REQ-022 The fill address counter SHALL be MAP_LOG2 or 2*MAP_LOG2 bits wide and SHALL terminate on the all-ones value, with no wrap-around write.
REQ-023 Op 11 SHALL be accepted, SHALL write nothing, and SHALL pulse done_out the next cycle.
REQ-024 busy_out SHALL be high exactly while the state is FILL or ROWFILL.
REQ-025 The read port SHALL have 2-cycle latency: rd_addr_in sampled at edge N SHALL appear on rd_data_out after edge N+2.
REQ-026 Read and write to the same address on the same edge SHALL be read-first, returning the old data.
REQ-027 Command inputs SHALL be ignored while cmd_ready_out is low, and no command SHALL be queued.

Reset
REQ-028 While rst_in is low: state IDLE, counters 0, rd_data_out 0, done_out 0, busy_out 0, and cmd_ready_out 1 once rst_in is released.
REQ-029 Map contents SHALL NOT be cleared by reset.
REQ-030 Reset asserted mid-fill SHALL abort the fill immediately, keep already-written words, and produce no done_out pulse.

Configuration
REQ-031 Macro TRACK_MAP_ROWFILL_EN defined: op 10 SHALL behave as in REQ-019.
REQ-032 Macro TRACK_MAP_ROWFILL_EN undefined: op 10 SHALL behave as op 11 (no write, done_out pulse), and the ROWFILL state logic SHALL be absent.

Verification
REQ-033 Write op with x=3, y=5, tile=7, then rd_addr=0x53 -> rd_data_out=7 two cycles after the address is applied; done_out high one cycle after acceptance.
REQ-034 Fill op with tile=2 -> busy_out high for 256 cycles, cmd_ready_out low during them, done_out pulse once; a read sweep 0x00..0xFF returns 2 everywhere.
REQ-035 Macro defined: after a fill with 2, row fill y=9 with tile=4 -> addresses 0x90..0x9F read 4, 0x8F and 0xA0 read 2, busy_out high for 16 cycles.
REQ-036 rst_in pulsed low after 100 cycles of a fill with 5 (previous map all 1) -> addresses 0x00..0x63 read 5, 0x64 and above read 1, no done_out, cmd_ready_out high after release.
REQ-037 Write 6 to 0x21 while rd_addr=0x21 on the same edge (old value 3) -> rd_data_out=3 two cycles later, then 6 on the next read.
REQ-038 Macro undefined: op 10 with y=0 -> map unchanged, done_out pulse next cycle, busy_out never high.
